// File: rtl/pkt_dispatch_pkg.sv
// Shared types and destination-decode helpers for the packet dispatcher.
package pkt_dispatch_pkg;

    localparam int MAX_PORTS  = 16;
    localparam int MAX_DEST_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        CAPT = 2'd2,
        SEND = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0]  id;
        logic [7:0]   src;
        logic [7:0]   dest;
        logic [127:0] payload;
    } packet_t;

    // True when the low dest_w bits of dest are all ones.
    function automatic logic bcast(input logic [MAX_DEST_W-1:0] dest,
                                   input int unsigned dest_w = 8);
        logic all_ones;
        all_ones = 1'b1;
        for (int i = 0; i < MAX_DEST_W; i++) begin
            if (i < dest_w && !dest[i]) all_ones = 1'b0;
        end
        return all_ones;
    endfunction

    // One-hot port select; all zeros when dest is out of range.
    function automatic logic [MAX_PORTS-1:0] port_mask(input logic [MAX_DEST_W-1:0] dest,
                                                       input int unsigned num_ports);
        logic [MAX_PORTS-1:0] mask;
        mask = '0;
        if (dest < num_ports) mask[dest[3:0]] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that takes priority over increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && count != {CNT_W{1'b1}}) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/packet_dispatcher.sv
// Pops packets from a queue and routes each to one/all egress ports or drops it.
// Optional per-port handshake counters and stats_clr under PKT_DISPATCH_STATS_EN.
module packet_dispatcher
    import pkt_dispatch_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int ID_W      = 32,
    parameter int SRC_W     = 8,
    parameter int DEST_W    = 8,
    parameter int PAYLOAD_W = 128,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_empty,
    output logic                 in_pop,
    input  logic [ID_W-1:0]      in_id,
    input  logic [SRC_W-1:0]     in_src,
    input  logic [DEST_W-1:0]    in_dest,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic [NUM_PORTS-1:0] eg_valid,
    input  logic [NUM_PORTS-1:0] eg_ready,
    output logic [ID_W-1:0]      eg_id,
    output logic [SRC_W-1:0]     eg_src,
    output logic [DEST_W-1:0]    eg_dest,
    output logic [PAYLOAD_W-1:0] eg_payload,
    output logic                 busy,
    output logic [CNT_W-1:0]     drop_cnt
`ifdef PKT_DISPATCH_STATS_EN
    ,
    output logic [NUM_PORTS*CNT_W-1:0] port_cnt,
    input  logic                       stats_clr
`endif
);

    state_t               state, state_nx;
    logic [NUM_PORTS-1:0] target, accepted, hs;
    logic [MAX_PORTS-1:0] pm;
    logic                 dest_bcast, dest_hit, send_done, drop_inc, cnt_clr;

    always_comb begin
        pm         = port_mask(MAX_DEST_W'(in_dest), NUM_PORTS);
        dest_bcast = bcast(MAX_DEST_W'(in_dest), DEST_W);
        dest_hit   = |pm;
        eg_valid   = (state == SEND) ? (target & ~accepted) : '0;
        hs         = eg_valid & eg_ready;
        send_done  = ((accepted | hs) == target);
        drop_inc   = (state == CAPT) && !dest_bcast && !dest_hit;
        busy       = (state != IDLE);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (!in_empty) state_nx = POP;
            POP:  state_nx = CAPT;
            CAPT: state_nx = (dest_bcast || dest_hit) ? SEND : IDLE;
            SEND: if (send_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_pop     <= 1'b0;
            target     <= '0;
            accepted   <= '0;
            eg_id      <= '0;
            eg_src     <= '0;
            eg_dest    <= '0;
            eg_payload <= '0;
        end else begin
            state  <= state_nx;
            in_pop <= (state_nx == POP);
            if (state == CAPT) begin
                eg_id      <= in_id;
                eg_src     <= in_src;
                eg_dest    <= in_dest;
                eg_payload <= in_payload;
                target     <= dest_bcast ? {NUM_PORTS{1'b1}} : pm[NUM_PORTS-1:0];
            end
            // Accepted ports stay masked until every target port has handshaken.
            if (state == SEND) begin
                accepted <= send_done ? '0 : (accepted | hs);
            end
        end
    end

`ifdef PKT_DISPATCH_STATS_EN
    assign cnt_clr = stats_clr;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port_cnt
        sat_counter #(.CNT_W(CNT_W)) u_port_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (hs[gi]),
            .clr   (stats_clr),
            .count (port_cnt[gi*CNT_W +: CNT_W])
        );
    end
`else
    assign cnt_clr = 1'b0;
`endif

    sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (drop_inc),
        .clr   (cnt_clr),
        .count (drop_cnt)
    );

endmodule

// File: tb/tb_packet_dispatcher.sv
// Directed self-checking bench for packet_dispatcher with a small queue model upstream.
module tb_packet_dispatcher;

    localparam int NP    = 4;
    localparam int CNT_W = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_empty;
    logic           in_pop;
    logic [31:0]    in_id;
    logic [7:0]     in_src;
    logic [7:0]     in_dest;
    logic [127:0]   in_payload;
    logic [NP-1:0]  eg_valid;
    logic [NP-1:0]  eg_ready;
    logic [31:0]    eg_id;
    logic [7:0]     eg_src;
    logic [7:0]     eg_dest;
    logic [127:0]   eg_payload;
    logic           busy;
    logic [CNT_W-1:0] drop_cnt;
`ifdef PKT_DISPATCH_STATS_EN
    logic [NP*CNT_W-1:0] port_cnt;
    logic                stats_clr;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int hs_cnt   = 0;

    logic [31:0]  q_id  [32];
    logic [7:0]   q_src [32];
    logic [7:0]   q_dest[32];
    logic [127:0] q_pay [32];
    int head = 0;
    int tail = 0;

    always #5 clk = ~clk;

    packet_dispatcher dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_empty   (in_empty),
        .in_pop     (in_pop),
        .in_id      (in_id),
        .in_src     (in_src),
        .in_dest    (in_dest),
        .in_payload (in_payload),
        .eg_valid   (eg_valid),
        .eg_ready   (eg_ready),
        .eg_id      (eg_id),
        .eg_src     (eg_src),
        .eg_dest    (eg_dest),
        .eg_payload (eg_payload),
        .busy       (busy),
        .drop_cnt   (drop_cnt)
`ifdef PKT_DISPATCH_STATS_EN
        ,
        .port_cnt   (port_cnt),
        .stats_clr  (stats_clr)
`endif
    );

    assign in_empty = (head == tail);

    always @(posedge clk) begin
        if (in_pop && head < tail) begin
            in_id      <= q_id[head];
            in_src     <= q_src[head];
            in_dest    <= q_dest[head];
            in_payload <= q_pay[head];
            head       <= head + 1;
        end
        if (rst_n) hs_cnt <= hs_cnt + $countones(eg_valid & eg_ready);
    end

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] id, input logic [7:0] src,
                        input logic [7:0] dest, input logic [127:0] pay);
        q_id[tail]   = id;
        q_src[tail]  = src;
        q_dest[tail] = dest;
        q_pay[tail]  = pay;
        tail = tail + 1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (eg_valid == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 128'(n < 20), 128'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || !in_empty) && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk(tag, 128'(busy), 128'd0);
    endtask

    initial begin
        int  hs0;
        logic seen;
        rst_n      = 1'b0;
        eg_ready   = '0;
        in_id      = '0;
        in_src     = '0;
        in_dest    = '0;
        in_payload = '0;
`ifdef PKT_DISPATCH_STATS_EN
        stats_clr  = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_in_pop", 128'(in_pop), 128'd0);
        chk("rst_eg_valid", 128'(eg_valid), 128'd0);
        chk("rst_eg_id", 128'(eg_id), 128'd0);
        chk("rst_eg_payload", eg_payload, 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_drop_cnt", 128'(drop_cnt), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // single unicast packet, latency and fields
        eg_ready = 4'b1111;
        push(32'h11, 8'h01, 8'd2, 128'hDEAD);
        chk("t1_pop_T", 128'(in_pop), 128'd0);
        @(negedge clk);
        chk("t1_pop_T1", 128'(in_pop), 128'd1);
        @(negedge clk);
        chk("t1_pop_T2", 128'(in_pop), 128'd0);
        chk("t1_valid_T2", 128'(eg_valid), 128'd0);
        @(negedge clk);
        chk("t1_valid_T3", 128'(eg_valid), 128'b0100);
        chk("t1_id", 128'(eg_id), 128'h11);
        chk("t1_src", 128'(eg_src), 128'h01);
        chk("t1_dest", 128'(eg_dest), 128'd2);
        chk("t1_payload", eg_payload, 128'hDEAD);
        chk("t1_busy", 128'(busy), 128'd1);
        @(negedge clk);
        chk("t1_busy_after", 128'(busy), 128'd0);
        chk("t1_valid_after", 128'(eg_valid), 128'd0);

        // back-pressure on port 1 with a second packet waiting
        eg_ready = 4'b1101;
        push(32'h22, 8'h02, 8'd1, 128'hBEEF);
        push(32'h23, 8'h02, 8'd0, 128'hCAFE);
        wait_valid("t2_wait");
        for (int i = 0; i < 10; i++) begin
            chk("t2_valid_hold", 128'(eg_valid), 128'b0010);
            chk("t2_id_stable", 128'(eg_id), 128'h22);
            chk("t2_payload_stable", eg_payload, 128'hBEEF);
            chk("t2_no_pop", 128'(in_pop), 128'd0);
            @(negedge clk);
        end
        eg_ready = 4'b1111;
        @(negedge clk);
        chk("t2_valid_drop", 128'(eg_valid), 128'd0);
        wait_valid("t2_wait2");
        chk("t2_second_valid", 128'(eg_valid), 128'b0001);
        chk("t2_second_id", 128'(eg_id), 128'h23);
        wait_idle("t2_idle");

        // broadcast accepted in order 0, 2, then 1 and 3
        eg_ready = 4'b0000;
        hs0 = hs_cnt;
        push(32'h33, 8'h03, 8'hFF, 128'h1234);
        wait_valid("t3_wait");
        chk("t3_valid_all", 128'(eg_valid), 128'b1111);
        eg_ready = 4'b0001;
        @(negedge clk);
        chk("t3_valid_after0", 128'(eg_valid), 128'b1110);
        eg_ready = 4'b0100;
        @(negedge clk);
        chk("t3_valid_after2", 128'(eg_valid), 128'b1010);
        chk("t3_busy_mid", 128'(busy), 128'd1);
        eg_ready = 4'b1010;
        @(negedge clk);
        chk("t3_valid_done", 128'(eg_valid), 128'd0);
        chk("t3_busy_done", 128'(busy), 128'd0);
        chk("t3_hs_count", 128'(hs_cnt - hs0), 128'd4);

        // invalid destinations are dropped
        eg_ready = 4'b1111;
        push(32'h44, 8'h04, 8'd7, 128'h44);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | (|eg_valid);
        end
        chk("t4_no_valid", 128'(seen), 128'd0);
        chk("t4_drop1", 128'(drop_cnt), 128'd1);
        push(32'h46, 8'h04, 8'h82, 128'h46);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | (|eg_valid);
        end
        chk("t4_highbit_no_valid", 128'(seen), 128'd0);
        chk("t4_drop2", 128'(drop_cnt), 128'd2);
        push(32'h45, 8'h04, 8'd0, 128'h45);
        wait_valid("t4_wait");
        chk("t4_next_valid", 128'(eg_valid), 128'b0001);
        chk("t4_next_id", 128'(eg_id), 128'h45);
        wait_idle("t4_idle");

        // reset during SEND discards the in-flight packet
        eg_ready = 4'b0000;
        push(32'h50, 8'h05, 8'd3, 128'h50);
        push(32'h55, 8'h05, 8'd0, 128'h55);
        wait_valid("t5_wait");
        chk("t5_valid_send", 128'(eg_valid), 128'b1000);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 128'(eg_valid), 128'd0);
        chk("t5_rst_busy", 128'(busy), 128'd0);
        chk("t5_rst_pop", 128'(in_pop), 128'd0);
        chk("t5_rst_drop", 128'(drop_cnt), 128'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        eg_ready = 4'b1111;
        wait_valid("t5_wait2");
        chk("t5_fresh_valid", 128'(eg_valid), 128'b0001);
        chk("t5_fresh_id", 128'(eg_id), 128'h55);
        wait_idle("t5_idle");

`ifdef PKT_DISPATCH_STATS_EN
        // per-port statistics and clear
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        chk("t6_clr_port", 128'(port_cnt), 128'd0);
        push(32'h60, 8'h06, 8'd0, 128'h60);
        push(32'h61, 8'h06, 8'd0, 128'h61);
        push(32'h62, 8'h06, 8'd0, 128'h62);
        push(32'h63, 8'h06, 8'hFF, 128'h63);
        push(32'h64, 8'h06, 8'd9, 128'h64);
        wait_idle("t6_idle");
        chk("t6_port0", 128'(port_cnt[0 +: CNT_W]), 128'd4);
        for (int p = 1; p < NP; p++) begin
            chk("t6_portn", 128'(port_cnt[p*CNT_W +: CNT_W]), 128'd1);
        end
        chk("t6_drop", 128'(drop_cnt), 128'd1);
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        chk("t6_clr_all_port", 128'(port_cnt), 128'd0);
        chk("t6_clr_drop", 128'(drop_cnt), 128'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
